perf_counter_bank: RTL and testbench



---
 rtl/perf_pkg.sv | 19 +
 rtl/perf_counter_slice.sv | 28 ++
 rtl/perf_counter_bank.sv | 87 ++++++++
 tb/tb_perf_counter_bank.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared state encoding and channel map for the performance counter bank
package perf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  localparam int CH_CYCLES  = 0;
  localparam int CH_FLUSH   = 1;
  localparam int CH_STALL   = 2;
  localparam int CH_FWD     = 3;
  localparam int CH_BRANCH  = 4;
  localparam int CH_JUMP    = 5;
  localparam int CH_MEM     = 6;
  localparam int CH_RETIRED = 7;

endpackage

// File: rtl/perf_counter_slice.sv
// rtl/perf_counter_slice.sv - one event counter with sticky overflow and wrap/saturate handling
module perf_counter_slice #(
  parameter int CNT_WIDTH = 32,
  parameter int SAT_MODE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ovf
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (count == {CNT_WIDTH{1'b1}}) begin
        ovf   <= 1'b1;
        count <= (SAT_MODE != 0) ? {CNT_WIDTH{1'b1}} : {CNT_WIDTH{1'b0}};
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - IDLE/RUN/FROZEN controlled bank of event counters with registered read port
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int SAT_MODE   = 1,
  parameter int SEL_W      = $clog2(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  clear,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_valid,
  output logic [NUM_EVENTS-1:0] ovf,
  output logic                  running,
  output logic                  frozen
);

  state_t                 state;
  state_t                 nextState;
  logic [NUM_EVENTS-1:0]  incVec;
  logic [CNT_WIDTH-1:0]   counts [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]   rdNext;

  always_comb begin
    nextState = state;
    if (clear) begin
      nextState = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start) nextState = ST_RUN;
        ST_RUN:    if (halt)  nextState = ST_FROZEN;
        ST_FROZEN: if (start) nextState = ST_RUN;
        default:   nextState = ST_IDLE;
      endcase
    end
  end

  // Cycle channel is forced on; a clearing cycle discards every increment.
  assign incVec = (state == ST_RUN && !clear)
                ? (event_in | (NUM_EVENTS'(1) << CH_CYCLES))
                : '0;

  for (genvar k = 0; k < NUM_EVENTS; k++) begin : gSlice
    perf_counter_slice #(
      .CNT_WIDTH (CNT_WIDTH),
      .SAT_MODE  (SAT_MODE)
    ) uSlice (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .inc   (incVec[k]),
      .count (counts[k]),
      .ovf   (ovf[k])
    );
  end

  // Unmatched selects (rd_sel >= NUM_EVENTS) fall through to zero.
  always_comb begin
    rdNext = '0;
    for (int k = 0; k < NUM_EVENTS; k++) begin
      if (rd_sel == SEL_W'(k)) rdNext = counts[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      running  <= 1'b0;
      frozen   <= 1'b0;
    end else begin
      state    <= nextState;
      rd_data  <= rdNext;
      rd_valid <= (nextState == ST_FROZEN);
      running  <= (nextState == ST_RUN);
      frozen   <= (nextState == ST_FROZEN);
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed self-checking bench for perf_counter_bank
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  eventIn = '0;
  logic [2:0]  rdSel = '0;

  logic [31:0] aData;  logic aValid;  logic [7:0] aOvf;  logic aRun;  logic aFrz;
  logic [3:0]  sData;  logic sValid;  logic [7:0] sOvf;  logic sRun;  logic sFrz;
  logic [3:0]  wData;  logic wValid;  logic [7:0] wOvf;  logic wRun;  logic wFrz;
  logic [31:0] oData;  logic oValid;  logic [5:0] oOvf;  logic oRun;  logic oFrz;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_EVENTS(8), .CNT_WIDTH(32), .SAT_MODE(1)) dutA (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .clear(clear),
    .event_in(eventIn), .rd_sel(rdSel), .rd_data(aData), .rd_valid(aValid),
    .ovf(aOvf), .running(aRun), .frozen(aFrz));

  perf_counter_bank #(.NUM_EVENTS(8), .CNT_WIDTH(4), .SAT_MODE(1)) dutS (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .clear(clear),
    .event_in(eventIn), .rd_sel(rdSel), .rd_data(sData), .rd_valid(sValid),
    .ovf(sOvf), .running(sRun), .frozen(sFrz));

  perf_counter_bank #(.NUM_EVENTS(8), .CNT_WIDTH(4), .SAT_MODE(0)) dutW (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .clear(clear),
    .event_in(eventIn), .rd_sel(rdSel), .rd_data(wData), .rd_valid(wValid),
    .ovf(wOvf), .running(wRun), .frozen(wFrz));

  perf_counter_bank #(.NUM_EVENTS(6), .CNT_WIDTH(32), .SAT_MODE(1)) dutO (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .clear(clear),
    .event_in(eventIn[5:0]), .rd_sel(rdSel), .rd_data(oData), .rd_valid(oValid),
    .ovf(oOvf), .running(oRun), .frozen(oFrz));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_and_halt;
    reset = 1'b1;
    tick(); tick();
    nTests++; if (aData !== 32'd0 || aValid !== 1'b0) begin nFail++; $display("FAIL reset_read: data %0d valid %b, want 0 0", aData, aValid); end
    nTests++; if (aOvf !== 8'h00 || aRun !== 1'b0 || aFrz !== 1'b0) begin nFail++; $display("FAIL reset_flags: ovf %h run %b frz %b, want 00 0 0", aOvf, aRun, aFrz); end
    reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    nTests++; if (aRun !== 1'b1 || aFrz !== 1'b0) begin nFail++; $display("FAIL start_run: run %b frz %b, want 1 0", aRun, aFrz); end
    for (int i = 0; i < 10; i++) begin
      eventIn = (i < 3) ? 8'h02 : 8'h00;
      tick();
    end
    eventIn = 8'h00;
    halt = 1'b1; tick(); halt = 1'b0;
    rdSel = 3'd0; tick();
    nTests++; if (aData !== 32'd11) begin nFail++; $display("FAIL halt_ch0: got %0d want 11", aData); end
    nTests++; if (aValid !== 1'b1 || aFrz !== 1'b1 || aRun !== 1'b0) begin nFail++; $display("FAIL halt_flags: valid %b frz %b run %b, want 1 1 0", aValid, aFrz, aRun); end
    rdSel = 3'd1; tick();
    nTests++; if (aData !== 32'd3) begin nFail++; $display("FAIL halt_ch1: got %0d want 3", aData); end
  endtask

  task automatic test_frozen_resume;
    eventIn = 8'hFF;
    rdSel = 3'd0;
    repeat (20) tick();
    nTests++; if (aData !== 32'd11) begin nFail++; $display("FAIL frozen_ch0: got %0d want 11", aData); end
    rdSel = 3'd1; tick();
    nTests++; if (aData !== 32'd3) begin nFail++; $display("FAIL frozen_ch1: got %0d want 3", aData); end
    eventIn = 8'h00;
    start = 1'b1; tick(); start = 1'b0;
    nTests++; if (aRun !== 1'b1 || aFrz !== 1'b0) begin nFail++; $display("FAIL resume_flags: run %b frz %b, want 1 0", aRun, aFrz); end
    rdSel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nTests++; if (aData !== 32'(11 + i) || aValid !== 1'b0) begin nFail++; $display("FAIL resume_ch0_%0d: got %0d valid %b want %0d 0", i, aData, aValid, 11 + i); end
    end
  endtask

  task automatic test_overflow;
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (19) tick();
    halt = 1'b1; tick(); halt = 1'b0;
    rdSel = 3'd0; tick();
    nTests++; if (sData !== 4'hF || sOvf[0] !== 1'b1) begin nFail++; $display("FAIL sat_ch0: data %h ovf %b, want f 1", sData, sOvf[0]); end
    nTests++; if (sOvf[7:1] !== 7'h00) begin nFail++; $display("FAIL sat_other_ovf: got %h want 00", sOvf[7:1]); end
    nTests++; if (wData !== 4'd4 || wOvf[0] !== 1'b1) begin nFail++; $display("FAIL wrap_ch0: data %0d ovf %b, want 4 1", wData, wOvf[0]); end
    nTests++; if (aData !== 32'd20 || aOvf !== 8'h00) begin nFail++; $display("FAIL wide_ch0: data %0d ovf %h, want 20 00", aData, aOvf); end
  endtask

  task automatic test_clear_priority;
    start = 1'b1; tick(); start = 1'b0;
    eventIn = 8'h04;
    tick(); tick();
    clear = 1'b1; halt = 1'b1; tick();
    clear = 1'b0; halt = 1'b0; eventIn = 8'h00;
    nTests++; if (aRun !== 1'b0 || aFrz !== 1'b0) begin nFail++; $display("FAIL clear_state: run %b frz %b, want 0 0", aRun, aFrz); end
    nTests++; if (sOvf !== 8'h00 || wOvf !== 8'h00) begin nFail++; $display("FAIL clear_ovf: sat %h wrap %h, want 00 00", sOvf, wOvf); end
    rdSel = 3'd0; tick();
    nTests++; if (aData !== 32'd0 || aValid !== 1'b0) begin nFail++; $display("FAIL clear_ch0: data %0d valid %b, want 0 0", aData, aValid); end
    rdSel = 3'd2; tick();
    nTests++; if (aData !== 32'd0) begin nFail++; $display("FAIL clear_ch2: got %0d want 0", aData); end
    start = 1'b1; tick(); start = 1'b0;
    rdSel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nTests++; if (aData !== 32'(i)) begin nFail++; $display("FAIL restart_ch0_%0d: got %0d want %0d", i, aData, i); end
    end
  endtask

  task automatic test_read_port;
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    eventIn = 8'h04; repeat (4) tick();
    eventIn = 8'h20; repeat (2) tick();
    eventIn = 8'h00;
    halt = 1'b1; tick(); halt = 1'b0;
    rdSel = 3'd2; tick();
    nTests++; if (aData !== 32'd4) begin nFail++; $display("FAIL read_ch2: got %0d want 4", aData); end
    rdSel = 3'd5;
    #1;
    nTests++; if (aData !== 32'd4) begin nFail++; $display("FAIL read_lag: got %0d want 4", aData); end
    tick();
    nTests++; if (aData !== 32'd2 || oData !== 32'd2) begin nFail++; $display("FAIL read_ch5: a %0d o %0d, want 2 2", aData, oData); end
    rdSel = 3'd0; tick();
    nTests++; if (aData !== 32'd7) begin nFail++; $display("FAIL read_ch0: got %0d want 7", aData); end
    rdSel = 3'd6; tick();
    nTests++; if (oData !== 32'd0) begin nFail++; $display("FAIL read_oob6: got %0d want 0", oData); end
    rdSel = 3'd0; tick();
    nTests++; if (oData !== 32'd7) begin nFail++; $display("FAIL read_narrow_ch0: got %0d want 7", oData); end
    rdSel = 3'd7; tick();
    nTests++; if (oData !== 32'd0 || oValid !== 1'b1) begin nFail++; $display("FAIL read_oob7: data %0d valid %b, want 0 1", oData, oValid); end
  endtask

  task automatic test_reset_mid_run;
    start = 1'b1; tick(); start = 1'b0;
    eventIn = 8'hFF; rdSel = 3'd0;
    repeat (3) tick();
    nTests++; if (aData !== 32'd9) begin nFail++; $display("FAIL pre_reset_ch0: got %0d want 9", aData); end
    reset = 1'b1; start = 1'b1; tick();
    reset = 1'b0; start = 1'b0; eventIn = 8'h00;
    nTests++; if (aData !== 32'd0 || aValid !== 1'b0 || aRun !== 1'b0 || aFrz !== 1'b0 || aOvf !== 8'h00) begin nFail++; $display("FAIL midrun_reset: data %0d valid %b run %b frz %b ovf %h, want 0 0 0 0 00", aData, aValid, aRun, aFrz, aOvf); end
    tick();
    nTests++; if (aData !== 32'd0 || aRun !== 1'b0 || wData !== 4'd0) begin nFail++; $display("FAIL post_reset_idle: a %0d run %b w %0d, want 0 0 0", aData, aRun, wData); end
    rdSel = 3'd5; tick();
    nTests++; if (aData !== 32'd0) begin nFail++; $display("FAIL post_reset_ch5: got %0d want 0", aData); end
  endtask

  initial begin
    test_reset_and_halt();
    test_frozen_resume();
    test_overflow();
    test_clear_priority();
    test_read_port();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
